// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM request arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    ACK
  } arb_state_t;

  // Widths sized for the largest supported configuration (4 ports, lock up to 16).
  localparam int unsigned ARB_MAX_REQ  = 4;
  localparam int unsigned ARB_MAX_LOCK = 16;
  localparam int unsigned PTR_W        = $clog2(ARB_MAX_REQ);
  localparam int unsigned LOCK_W       = $clog2(ARB_MAX_LOCK);
  localparam int unsigned PERF_W       = 32;

endpackage

// File: rtl/sdram_req_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr_i, circularly.
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_c,
  output logic [PTR_W-1:0] idx_c,
  output logic             any_c
);

  logic found;

  // Scan by distance from the pointer so the nearest requester wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    for (int unsigned d = 0; d < N; d++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req_i[j] && (((32'(ptr_i) + d) % N) == j)) begin
          gnt_c[j] = 1'b1;
          idx_c    = PTR_W'(j);
          found    = 1'b1;
        end
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin, burst-lockable arbiter sharing one SDRAM command port.
// Optional performance counters enabled by defining SDRAM_ARB_PERF_EN.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          we_i,
  input  logic [NUM_REQ-1:0]          lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        cmd_valid_o,
  input  logic                        cmd_ready_i,
  output logic                        cmd_we_o,
  output logic [ADDR_W-1:0]           cmd_addr_o,
  output logic [DATA_W-1:0]           cmd_wdata_o,
  input  logic                        rsp_valid_i,
  input  logic [DATA_W-1:0]           rsp_rdata_i,
  input  logic                        perf_clr_i,
  output logic [NUM_REQ*PERF_W-1:0]   perf_grant_o,
  output logic [NUM_REQ*PERF_W-1:0]   perf_wait_o
);

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_cnt_d  = lock_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ack_d       = '0;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_gnt;
          gnt_idx_d   = pick_idx;
          cmd_valid_d = 1'b1;
          for (int unsigned p = 0; p < NUM_REQ; p++) begin
            if (pick_gnt[p]) begin
              cmd_we_d    = we_i[p];
              cmd_addr_d  = addr_i[p*ADDR_W +: ADDR_W];
              cmd_wdata_d = wdata_i[p*DATA_W +: DATA_W];
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          if (cmd_we_q) begin
            ack_d   = gnt_q;
            state_d = ACK;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (rsp_valid_i) begin
          rdata_d = rsp_rdata_i;
          ack_d   = gnt_q;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
        // A locked port keeps priority until it has used its burst allowance.
        if ((|(lock_i & gnt_q)) && (lock_cnt_q < LOCK_W'(MAX_LOCK - 1))) begin
          rr_ptr_d   = gnt_idx_q;
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end else begin
          rr_ptr_d   = (gnt_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + PTR_W'(1);
          lock_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_cnt_q  <= lock_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_we_o    = cmd_we_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_wdata_o = cmd_wdata_q;

`ifdef SDRAM_ARB_PERF_EN
  logic [NUM_REQ*PERF_W-1:0] perf_grant_q, perf_grant_d;
  logic [NUM_REQ*PERF_W-1:0] perf_wait_q, perf_wait_d;

  // Saturating per-port counters; a clear overrides any increment.
  always_comb begin
    perf_grant_d = perf_grant_q;
    perf_wait_d  = perf_wait_q;
    for (int unsigned p = 0; p < NUM_REQ; p++) begin
      if (perf_clr_i) begin
        perf_grant_d[p*PERF_W +: PERF_W] = '0;
        perf_wait_d[p*PERF_W +: PERF_W]  = '0;
      end else begin
        if ((state_q == ACK) && gnt_q[p] && (perf_grant_q[p*PERF_W +: PERF_W] != '1)) begin
          perf_grant_d[p*PERF_W +: PERF_W] = perf_grant_q[p*PERF_W +: PERF_W] + PERF_W'(1);
        end
        if (req_i[p] && !((state_q == IDLE) ? pick_gnt[p] : gnt_q[p]) &&
            (perf_wait_q[p*PERF_W +: PERF_W] != '1)) begin
          perf_wait_d[p*PERF_W +: PERF_W] = perf_wait_q[p*PERF_W +: PERF_W] + PERF_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_grant_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_grant_o = perf_grant_q;
  assign perf_wait_o  = perf_wait_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign perf_grant_o    = '0;
  assign perf_wait_o     = '0;
`endif

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter (2 ports, MAX_LOCK=8).
module tb_sdram_req_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_i, we_i, lock_i;
  logic [NR*AW-1:0]  addr_i;
  logic [NR*DW-1:0]  wdata_i;
  logic [NR-1:0]     ack_o;
  logic [DW-1:0]     rdata_o;
  logic              cmd_valid_o, cmd_ready_i, cmd_we_o;
  logic [AW-1:0]     cmd_addr_o;
  logic [DW-1:0]     cmd_wdata_o;
  logic              rsp_valid_i;
  logic [DW-1:0]     rsp_rdata_i;
  logic              perf_clr_i;
  logic [NR*32-1:0]  perf_grant_o, perf_wait_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  sdram_req_arbiter #(.NUM_REQ(2), .ADDR_W(23), .DATA_W(32), .MAX_LOCK(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .lock_i       (lock_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready_i),
    .cmd_we_o     (cmd_we_o),
    .cmd_addr_o   (cmd_addr_o),
    .cmd_wdata_o  (cmd_wdata_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_rdata_i  (rsp_rdata_i),
    .perf_clr_i   (perf_clr_i),
    .perf_grant_o (perf_grant_o),
    .perf_wait_o  (perf_wait_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = '0; we_i = '0; lock_i = '0; addr_i = '0; wdata_i = '0;
    cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_rdata_i = '0; perf_clr_i = 1'b0;
    step(); step();
    tot_cnt++; if (cmd_valid_o !== 1'b0) $display("FAIL rst_cmd_valid got %b exp 0", cmd_valid_o); else pass_cnt++;
    tot_cnt++; if (ack_o !== 2'b00) $display("FAIL rst_ack got %b exp 00", ack_o); else pass_cnt++;
    tot_cnt++; if (rdata_o !== 32'h0) $display("FAIL rst_rdata got %h exp 0", rdata_o); else pass_cnt++;
    tot_cnt++; if (cmd_addr_o !== 23'h0 || cmd_we_o !== 1'b0 || cmd_wdata_o !== 32'h0)
      $display("FAIL rst_payload got we=%b a=%h d=%h exp 0", cmd_we_o, cmd_addr_o, cmd_wdata_o); else pass_cnt++;
    tot_cnt++; if (perf_grant_o !== 64'h0 || perf_wait_o !== 64'h0)
      $display("FAIL rst_perf got g=%h w=%h exp 0", perf_grant_o, perf_wait_o); else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    req_i = 2'b01; we_i = 2'b01; cmd_ready_i = 1'b1;
    addr_i[AW-1:0] = 23'h000010; wdata_i[DW-1:0] = 32'hDEADBEEF;
    step();
    tot_cnt++; if (cmd_valid_o !== 1'b1 || cmd_we_o !== 1'b1 || cmd_addr_o !== 23'h10 || cmd_wdata_o !== 32'hDEADBEEF)
      $display("FAIL wr_cmd got v=%b we=%b a=%h d=%h exp 1 1 10 deadbeef", cmd_valid_o, cmd_we_o, cmd_addr_o, cmd_wdata_o);
    else pass_cnt++;
    tot_cnt++; if (ack_o !== 2'b00) $display("FAIL wr_ack_early got %b exp 00", ack_o); else pass_cnt++;
    step();
    tot_cnt++; if (ack_o !== 2'b01 || cmd_valid_o !== 1'b0)
      $display("FAIL wr_ack got ack=%b v=%b exp 01 0", ack_o, cmd_valid_o); else pass_cnt++;
    req_i = 2'b00;
    step();
    tot_cnt++; if (ack_o !== 2'b00) $display("FAIL wr_single_pulse got %b exp 00", ack_o); else pass_cnt++;
  endtask

  task automatic test_read_backpressure();
    cmd_ready_i = 1'b0; req_i = 2'b10; we_i = 2'b00;
    addr_i[2*AW-1:AW] = 23'h000040; wdata_i[2*DW-1:DW] = 32'hCAFEF00D;
    step();
    for (int i = 0; i < 5; i++) begin
      tot_cnt++; if (cmd_valid_o !== 1'b1 || cmd_we_o !== 1'b0 || cmd_addr_o !== 23'h40)
        $display("FAIL rd_stall_hold[%0d] got v=%b we=%b a=%h exp 1 0 40", i, cmd_valid_o, cmd_we_o, cmd_addr_o);
      else pass_cnt++;
      if (i == 2) begin rsp_valid_i = 1'b1; rsp_rdata_i = 32'hBADBAD00; end
      if (i == 3) rsp_valid_i = 1'b0;
      step();
    end
    tot_cnt++; if (rdata_o !== 32'h0) $display("FAIL rd_stray_rsp got %h exp 0", rdata_o); else pass_cnt++;
    cmd_ready_i = 1'b1;
    step();
    cmd_ready_i = 1'b0;
    tot_cnt++; if (cmd_valid_o !== 1'b0 || ack_o !== 2'b00)
      $display("FAIL rd_handshake got v=%b ack=%b exp 0 00", cmd_valid_o, ack_o); else pass_cnt++;
    step(); step();
    tot_cnt++; if (ack_o !== 2'b00) $display("FAIL rd_wait got %b exp 00", ack_o); else pass_cnt++;
    rsp_valid_i = 1'b1; rsp_rdata_i = 32'h12345678;
    step();
    rsp_valid_i = 1'b0;
    tot_cnt++; if (ack_o !== 2'b10 || rdata_o !== 32'h12345678)
      $display("FAIL rd_ack got ack=%b d=%h exp 10 12345678", ack_o, rdata_o); else pass_cnt++;
    req_i = 2'b00;
    step();
    tot_cnt++; if (ack_o !== 2'b00 || rdata_o !== 32'h12345678)
      $display("FAIL rd_after got ack=%b d=%h exp 00 12345678", ack_o, rdata_o); else pass_cnt++;
    cmd_ready_i = 1'b1;
  endtask

  task automatic test_round_robin();
    int n_ack = 0;
    int c0 = 0;
    int c1 = 0;
    int cyc = 0;
    logic [1:0] exp_ack;
`ifdef SDRAM_ARB_PERF_EN
    perf_clr_i = 1'b1; step(); perf_clr_i = 1'b0;
`endif
    cmd_ready_i = 1'b1; we_i = 2'b11; lock_i = 2'b00; req_i = 2'b11;
    while (n_ack < 10 && cyc < 200) begin
      step(); cyc++;
      if (ack_o !== 2'b00) begin
        exp_ack = (n_ack % 2 == 1) ? 2'b10 : 2'b01;
        tot_cnt++; if (ack_o !== exp_ack) $display("FAIL rr_order[%0d] got %b exp %b", n_ack, ack_o, exp_ack); else pass_cnt++;
        if (ack_o === 2'b01) c0++;
        if (ack_o === 2'b10) c1++;
        n_ack++;
        if (n_ack == 10) req_i = 2'b00;
      end
    end
    tot_cnt++; if (n_ack != 10) $display("FAIL rr_timeout got %0d acks exp 10", n_ack); else pass_cnt++;
    tot_cnt++; if (c0 != 5 || c1 != 5) $display("FAIL rr_counts got %0d,%0d exp 5,5", c0, c1); else pass_cnt++;
    tot_cnt++; if (rdata_o !== 32'h12345678) $display("FAIL rr_rdata_kept got %h exp 12345678", rdata_o); else pass_cnt++;
    step();
`ifdef SDRAM_ARB_PERF_EN
    tot_cnt++; if (perf_grant_o !== {32'd5, 32'd5}) $display("FAIL perf_grant got %h exp 5,5", perf_grant_o); else pass_cnt++;
    perf_clr_i = 1'b1; step(); perf_clr_i = 1'b0;
    tot_cnt++; if (perf_grant_o !== 64'h0 || perf_wait_o !== 64'h0)
      $display("FAIL perf_clear got g=%h w=%h exp 0", perf_grant_o, perf_wait_o); else pass_cnt++;
`else
    tot_cnt++; if (perf_grant_o !== 64'h0 || perf_wait_o !== 64'h0)
      $display("FAIL perf_tied got g=%h w=%h exp 0", perf_grant_o, perf_wait_o); else pass_cnt++;
`endif
  endtask

  task automatic test_lock();
    int n_ack = 0;
    int cyc = 0;
    logic [1:0] exp_ack;
    lock_i = 2'b01; we_i = 2'b11; req_i = 2'b11;
    while (n_ack < 18 && cyc < 400) begin
      step(); cyc++;
      if (ack_o !== 2'b00) begin
        exp_ack = (n_ack % 9 == 8) ? 2'b10 : 2'b01;
        tot_cnt++; if (ack_o !== exp_ack) $display("FAIL lock_order[%0d] got %b exp %b", n_ack, ack_o, exp_ack); else pass_cnt++;
        n_ack++;
        if (n_ack == 18) req_i = 2'b00;
      end
    end
    tot_cnt++; if (n_ack != 18) $display("FAIL lock_timeout got %0d acks exp 18", n_ack); else pass_cnt++;
    step();
    lock_i = 2'b00;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    logic [1:0] got;
    req_i = 2'b01; we_i = 2'b01;
    step(); step();
    req_i = 2'b00;
    step();
    req_i = 2'b10; we_i = 2'b00;
    step(); step();
    tot_cnt++; if (cmd_valid_o !== 1'b0 || ack_o !== 2'b00)
      $display("FAIL mid_in_wait got v=%b ack=%b exp 0 00", cmd_valid_o, ack_o); else pass_cnt++;
    rst_n = 1'b0;
    step();
    tot_cnt++; if (cmd_valid_o !== 1'b0 || ack_o !== 2'b00)
      $display("FAIL mid_rst got v=%b ack=%b exp 0 00", cmd_valid_o, ack_o); else pass_cnt++;
    rst_n = 1'b1; req_i = 2'b00;
    rsp_valid_i = 1'b1; rsp_rdata_i = 32'hFEEDFACE;
    step();
    rsp_valid_i = 1'b0;
    tot_cnt++; if (ack_o !== 2'b00 || rdata_o !== 32'h0)
      $display("FAIL mid_late_rsp got ack=%b d=%h exp 00 0", ack_o, rdata_o); else pass_cnt++;
    req_i = 2'b11; we_i = 2'b11;
    got = 2'b00;
    while (got === 2'b00 && cyc < 20) begin
      step(); cyc++;
      got = ack_o;
    end
    tot_cnt++; if (got !== 2'b01) $display("FAIL mid_next_port got %b exp 01", got); else pass_cnt++;
    req_i = 2'b00;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_backpressure();
    test_round_robin();
    test_lock();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
